mac_mul_sign_restore: RTL and testbench
=======================================

// Module: mac_mul_sign_restore
// PURPOSE
// - Output-side counterpart of the operand negator: takes unsigned partial-product magnitudes from the
//   multiplier array plus per-lane sign flags and restores two's-complement products.
// - Sits between the multiplier array and the accumulator.
// - Carry chain is configurable: Single (4 x 16b), Dual (2 x 32b) or Quad (1 x 64b).
// - 2-stage valid/ready pipeline; the carry is registered between chunk 1 and chunk 2.
// PARAMETERS
// - MAC_CONF_WIDTH  4                  cfg width: [3] signed, [2] mac/mul (ignored), [1:0] mode
// - MAC_MIN_WIDTH   8                  minimum operand width
// - MAC_MULT_WIDTH  2*MAC_MIN_WIDTH    width of one product chunk Pk
// PORTS
// - clk        in   1       clock
// - rst        in   1       asynchronous, active-high reset
// - en         in   1       0 = whole pipeline frozen; no accept, no advance, outputs held
// - cfg        in   4       mode/sign config, sampled together with the input data
// - in_valid   in   1       input beat valid
// - in_ready   out  1       block accepts a beat this cycle
// - P0_in..P3_in  in   MULT  product magnitude chunks, P0 least significant
// - C0_neg..C3_neg in 1     sign flag of product lane k (from the negator block)
// - out_valid  out  1       output beat valid
// - out_ready  in   1       downstream accepts
// - P0_out..P3_out out MULT restored product chunks
// - neg_out    out  4       per-chunk negate-applied flags, aligned with P*_out
// BEHAVIOUR
// - Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, P*_out=0, neg_out=0; in_ready=0 while rst=1.
// - Mode decode on the sampled cfg[1:0]:
//   - quad = 2'b10
//   - dual = 2'b01
//   - single = every other value, including 2'b11
// - Negate select for chunk k: sel_k = cfg[3] & S_k, where
//   - single: S_k = Ck_neg
//   - dual:   S0 = S1 = C1_neg; S2 = S3 = C3_neg
//   - quad:   S_k = C3_neg for all k
// - Chunk k computes nk = ~Pk + cin_k, giving a carry out ck. The final chunk value is nk when sel_k = 1, else Pk.
// - Carry-ins:
//   - cin0 = 1
//   - cin1 = single ? 1 : c0
//   - cin2 = quad ? c1 : 1
//   - cin3 = single ? 1 : c2
// - Stage 1 (on accept):
//   - registers the final chunks 0 and 1, raw P2/P3, sel[3:0], the mode, and c1.
//   - c1 is computed as a plain carry; it is only consumed in quad mode.
// - Stage 2: computes chunks 2 and 3 from the registered c1, then registers all four chunks and neg_out = sel.
// - Latency: an accepted beat appears on out 2 cycles later, provided there is no stall.
// - Throughput: 1 beat per cycle.
// - Handshake:
//   - adv2 = en & s1_valid & (~s2_valid | out_ready)
//   - in_ready = en & (~s1_valid | adv2)
//   - an accept happens when in_valid & in_ready
// - out_valid = s2_valid. Out data holds stable while out_valid & ~out_ready, and the output drops when out_ready & ~adv2.
// - Simultaneous pop and push when full: both happen in the same cycle, with no bubble.
// - Unsigned (cfg[3]=0): pure pass-through with 2-cycle latency; neg_out = 0.
// - Boundaries:
//   - A zero magnitude with sel = 1 yields 0: the carry ripples out of each chunk.
//   - In quad mode, a zero low half must propagate the carry through the stage register into chunk 2.
// - Mid-operation reset discards every in-flight beat. en = 0 never drops or duplicates a beat.
// STRUCTURE
// - Shared package/header (mac_const.vh): the mode encodings MAC_MODE_SINGLE/DUAL/QUAD, and the cfg bit indices
//   SIGNED_BIT = 3 and MODE_LSB = 0.
// - Sub-module: the existing n_bit_one_adder (N = MAC_MULT_WIDTH), instantiated 4 times (one per chunk).
// - The remaining logic is carry muxes plus two pipeline register banks.
// TESTING
// - Single, signed:
//   - stimulus: P = {0x0010, 0x3F01, 0x0000, 0x4000}, C = {1,0,1,1}
//   - response: out = {0xFFF0, 0x3F01, 0x0000, 0xC000}, neg_out = 4'b1011
// - Dual, signed:
//   - stimulus: P1:P0 = 0x0000_0001, C1 = 1; P3:P2 = 0x0001_0000, C3 = 0
//   - response: out P1:P0 = 0xFFFF_FFFF, P3:P2 = 0x0001_0000
// - Quad, signed:
//   - stimulus: P = 0x0000_0001_0000_0000, C3 = 1
//   - response: 0xFFFF_FFFF_0000_0000, which requires the registered carry
// - Unsigned: cfg[3] = 0 with every C = 1 -> out equals in, neg_out = 0.
// - Backpressure:
//   - stimulus: stream 4 beats, hold out_ready = 0 for 3 cycles
//   - response: in_ready falls after 2 beats; all beats arrive in order with no loss; full throughput on release
// - Reset and enable:
//   - rst pulse with beats in flight -> out_valid = 0 immediately and no stale beat afterwards
//   - en = 0 for 2 cycles mid-stream -> outputs frozen, sequence intact

Source files
------------

// File: rtl/mac_mul_sign_restore_pkg.sv
// rtl/mac_mul_sign_restore_pkg.sv - mode encodings and cfg field positions for the sign-restore stage
package mac_mul_sign_restore_pkg;

    localparam logic [1:0] MAC_MODE_SINGLE = 2'b00;
    localparam logic [1:0] MAC_MODE_DUAL   = 2'b01;
    localparam logic [1:0] MAC_MODE_QUAD   = 2'b10;

    localparam int SIGNED_BIT = 3;
    localparam int MODE_LSB   = 0;

    typedef enum logic [1:0] {
        MODE_SINGLE = MAC_MODE_SINGLE,
        MODE_DUAL   = MAC_MODE_DUAL,
        MODE_QUAD   = MAC_MODE_QUAD
    } mode_e;

    // 2'b11 is not a chained mode, so it falls back to independent lanes
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            MAC_MODE_DUAL: decode_mode = MODE_DUAL;
            MAC_MODE_QUAD: decode_mode = MODE_QUAD;
            default:       decode_mode = MODE_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/n_bit_one_adder.sv
// rtl/n_bit_one_adder.sv - adds a single carry-in bit to an N-bit word, exposing the carry out
module n_bit_one_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mac_mul_sign_restore.sv
// rtl/mac_mul_sign_restore.sv - restores two's-complement products from magnitudes and lane sign flags
module mac_mul_sign_restore
    import mac_mul_sign_restore_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAC_MULT_WIDTH-1:0] P0_in,
    input  logic [MAC_MULT_WIDTH-1:0] P1_in,
    input  logic [MAC_MULT_WIDTH-1:0] P2_in,
    input  logic [MAC_MULT_WIDTH-1:0] P3_in,
    input  logic                      C0_neg,
    input  logic                      C1_neg,
    input  logic                      C2_neg,
    input  logic                      C3_neg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_MULT_WIDTH-1:0] P0_out,
    output logic [MAC_MULT_WIDTH-1:0] P1_out,
    output logic [MAC_MULT_WIDTH-1:0] P2_out,
    output logic [MAC_MULT_WIDTH-1:0] P3_out,
    output logic [3:0]                neg_out
);

    localparam int W = MAC_MULT_WIDTH;

    logic          s1_valid;
    logic [W-1:0]  s1_chunk0, s1_chunk1, s1_p2, s1_p3;
    logic [3:0]    s1_sel;
    mode_e         s1_mode;
    logic          s1_c1;
    logic          s2_valid;

    logic          adv2, accept;
    mode_e         in_mode;
    logic          in_signed;
    logic [3:0]    in_sel;
    logic          cin1, cin2, cin3;
    logic          c0, c1, c2, c3_unused;
    logic [W-1:0]  n0, n1, n2, n3;
    logic          cfg_mac_unused;

    // mac/mul selection belongs to the accumulator; this stage does not need it
    assign cfg_mac_unused = cfg[2];

    assign adv2     = en & s1_valid & (~s2_valid | out_ready);
    assign in_ready = en & ~rst & (~s1_valid | adv2);
    assign accept   = in_valid & in_ready;

    assign in_mode   = decode_mode(cfg[MODE_LSB +: 2]);
    assign in_signed = cfg[SIGNED_BIT];

    always_comb begin
        in_sel = 4'b0000;
        case (in_mode)
            MODE_QUAD: in_sel = {4{C3_neg}};
            MODE_DUAL: in_sel = {C3_neg, C3_neg, C1_neg, C1_neg};
            default:   in_sel = {C3_neg, C2_neg, C1_neg, C0_neg};
        endcase
        in_sel = in_sel & {4{in_signed}};
    end

    // Stage 1 chunks: negation is ~P + 1 with the carry chained across lanes of one product
    assign cin1 = (in_mode == MODE_SINGLE) ? 1'b1 : c0;

    n_bit_one_adder #(.N(W)) u_add0 (.a(~P0_in), .cin(1'b1), .sum(n0), .cout(c0));
    n_bit_one_adder #(.N(W)) u_add1 (.a(~P1_in), .cin(cin1), .sum(n1), .cout(c1));

    // Stage 2 chunks: only quad mode continues the chain across the stage register
    assign cin2 = (s1_mode == MODE_QUAD) ? s1_c1 : 1'b1;
    assign cin3 = (s1_mode == MODE_SINGLE) ? 1'b1 : c2;

    n_bit_one_adder #(.N(W)) u_add2 (.a(~s1_p2), .cin(cin2), .sum(n2), .cout(c2));
    n_bit_one_adder #(.N(W)) u_add3 (.a(~s1_p3), .cin(cin3), .sum(n3), .cout(c3_unused));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_chunk0 <= '0;
            s1_chunk1 <= '0;
            s1_p2     <= '0;
            s1_p3     <= '0;
            s1_sel    <= 4'b0000;
            s1_mode   <= MODE_SINGLE;
            s1_c1     <= 1'b0;
        end else if (en) begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_chunk0 <= in_sel[0] ? n0 : P0_in;
                s1_chunk1 <= in_sel[1] ? n1 : P1_in;
                s1_p2     <= P2_in;
                s1_p3     <= P3_in;
                s1_sel    <= in_sel;
                s1_mode   <= in_mode;
                s1_c1     <= c1;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            P0_out   <= '0;
            P1_out   <= '0;
            P2_out   <= '0;
            P3_out   <= '0;
            neg_out  <= 4'b0000;
        end else if (en) begin
            if (adv2) begin
                s2_valid <= 1'b1;
                P0_out   <= s1_chunk0;
                P1_out   <= s1_chunk1;
                P2_out   <= s1_sel[2] ? n2 : s1_p2;
                P3_out   <= s1_sel[3] ? n3 : s1_p3;
                neg_out  <= s1_sel;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_mac_mul_sign_restore.sv
// tb/tb_mac_mul_sign_restore.sv - scoreboard bench for mac_mul_sign_restore
module tb_mac_mul_sign_restore;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  cfg;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] P0_in, P1_in, P2_in, P3_in;
    logic        C0_neg, C1_neg, C2_neg, C3_neg;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] P0_out, P1_out, P2_out, P3_out;
    logic [3:0]  neg_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [67:0] exp_q[$];

    always #5 clk = ~clk;

    mac_mul_sign_restore dut (
        .clk(clk), .rst(rst), .en(en), .cfg(cfg),
        .in_valid(in_valid), .in_ready(in_ready),
        .P0_in(P0_in), .P1_in(P1_in), .P2_in(P2_in), .P3_in(P3_in),
        .C0_neg(C0_neg), .C1_neg(C1_neg), .C2_neg(C2_neg), .C3_neg(C3_neg),
        .out_valid(out_valid), .out_ready(out_ready),
        .P0_out(P0_out), .P1_out(P1_out), .P2_out(P2_out), .P3_out(P3_out),
        .neg_out(neg_out)
    );

    function automatic logic [67:0] model(input logic [63:0] p, input logic [3:0] c, input logic [3:0] cf);
        logic       s = cf[3];
        logic [3:0] sel;
        logic [63:0] r;
        case (cf[1:0])
            2'b10: begin
                sel = {4{s & c[3]}};
                r = sel[0] ? (64'd0 - p) : p;
            end
            2'b01: begin
                sel = {{2{s & c[3]}}, {2{s & c[1]}}};
                r[31:0]  = sel[0] ? (32'd0 - p[31:0])  : p[31:0];
                r[63:32] = sel[2] ? (32'd0 - p[63:32]) : p[63:32];
            end
            default: begin
                sel = s ? c : 4'b0000;
                for (int k = 0; k < 4; k++)
                    r[16*k +: 16] = sel[k] ? (16'd0 - p[16*k +: 16]) : p[16*k +: 16];
            end
        endcase
        return {sel, r};
    endfunction

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [67:0] dut_out();
        return {neg_out, P3_out, P2_out, P1_out, P0_out};
    endfunction

    // Output monitor: a transfer needs the pipeline enabled as well as the handshake
    always @(negedge clk) begin
        if (!rst && en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", dut_out(), 68'h0);
            end else begin
                check("beat", dut_out(), exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic [63:0] p, input logic [3:0] c, input logic [3:0] cf);
        {P3_in, P2_in, P1_in, P0_in} = p;
        {C3_neg, C2_neg, C1_neg, C0_neg} = c;
        cfg = cf;
        in_valid = 1'b1;
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic send(input logic [63:0] p, input logic [3:0] c, input logic [3:0] cf,
                        input logic [67:0] exp, output int waited);
        waited = 0;
        drive(p, c, cf);
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        n_checks++;
        assert (in_ready === 1'b1) else begin
            n_errors++;
            $error("FAIL accept_timeout observed=%b expected=1", in_ready);
        end
        if (in_ready) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_left", 68'(exp_q.size()), 68'h0);
    endtask

    initial begin
        int w;
        logic [63:0] p;
        logic [3:0]  c, cf;
        logic [67:0] held;

        rst = 1'b1; en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        drive(64'h0, 4'h0, 4'h0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_state", {in_ready, out_valid, dut_out()}, 70'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        send(64'h0010_3F01_0000_4000, 4'b1011, 4'b1000, {4'b1011, 64'hFFF0_3F01_0000_C000}, w);
        send(64'h0001_0000_0000_0001, 4'b0010, 4'b1001, {4'b0011, 64'h0001_0000_FFFF_FFFF}, w);
        send(64'h0000_0001_0000_0000, 4'b1000, 4'b1010, {4'b1111, 64'hFFFF_FFFF_0000_0000}, w);
        send(64'h1234_5678_9ABC_DEF0, 4'b1111, 4'b0000, {4'b0000, 64'h1234_5678_9ABC_DEF0}, w);
        send(64'hFEDC_BA98_7654_3210, 4'b1111, 4'b0010, {4'b0000, 64'hFEDC_BA98_7654_3210}, w);
        send(64'h0, 4'b1111, 4'b1000, {4'b1111, 64'h0}, w);
        send(64'h0, 4'b1000, 4'b1010, {4'b1111, 64'h0}, w);
        send(64'h0000_0000_0000_0003, 4'b1000, 4'b1110, {4'b1111, 64'hFFFF_FFFF_FFFF_FFFD}, w);
        send(64'h0001_0002_0003_0004, 4'b0101, 4'b1011, {4'b0101, 64'h0001_FFFE_0003_FFFC}, w);
        for (int i = 0; i < 20; i++) begin
            p = {$urandom, $urandom};
            c = 4'($urandom_range(0, 15));
            cf = 4'($urandom_range(0, 15));
            send(p, c, cf, model(p, c, cf), w);
        end
        drain();

        // Backpressure: two beats fill both stages, third must wait
        out_ready = 1'b0;
        send(64'h0000_0000_0000_0005, 4'b0001, 4'b1000, model(64'h5, 4'b0001, 4'b1000), w);
        send(64'h0000_0000_0007_0000, 4'b0010, 4'b1000, model(64'h70000, 4'b0010, 4'b1000), w);
        @(negedge clk);
        check("bp_in_ready_low", {in_ready, out_valid}, 68'b01);
        held = dut_out();
        @(negedge clk);
        check("bp_hold_stable", dut_out(), held);
        check("bp_in_ready_still_low", {67'h0, in_ready}, 68'h0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(64'h0000_0009_0000_0000, 4'b0100, 4'b1000, model(64'h9_0000_0000, 4'b0100, 4'b1000), w);
        check("release_no_wait_c", 68'(w), 68'h0);
        send(64'h000B_0000_0000_0000, 4'b1000, 4'b1001, model(64'hB_0000_0000_0000, 4'b1000, 4'b1001), w);
        check("release_no_wait_d", 68'(w), 68'h0);
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        send(64'h1111, 4'b0001, 4'b1000, model(64'h1111, 4'b0001, 4'b1000), w);
        send(64'h2222, 4'b0001, 4'b1000, model(64'h2222, 4'b0001, 4'b1000), w);
        rst = 1'b1;
        #1;
        check("rst_async_clear", {in_ready, out_valid, dut_out()}, 70'h0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_after_rst", {67'h0, out_valid}, 68'h0);
        end

        // Enable low freezes a beat sitting in stage 1
        @(posedge clk);
        #1;
        send(64'h0000_0000_0000_00AA, 4'b0001, 4'b1000, model(64'hAA, 4'b0001, 4'b1000), w);
        en = 1'b0;
        drive(64'h0000_0000_0000_00BB, 4'b0001, 4'b1000);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("en_low_frozen", {66'h0, in_ready, out_valid}, 68'h0);
        end
        @(posedge clk);
        #1 en = 1'b1;
        send(64'h0000_0000_0000_00BB, 4'b0001, 4'b1000, model(64'hBB, 4'b0001, 4'b1000), w);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
